regfile_scb: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU core, succeeding the fixed 32x32 single-write-port file. It has two write ports (early EX result, MEM/WB result), write-to-read bypass on both read ports, a per-register busy scoreboard for the hazard unit, and a debug read port for the board display. Writes are on the rising clock edge, with same-cycle forwarding. No split-phase negedge write is used.

---
 rtl/regfile_scb.sv | 141 ++++++++++++++
 tb/tb_regfile_scb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scb.sv
// regfile_scb: parametrised register file with two write ports.
// Both read ports see same-cycle writes through a bypass. A per-register busy
// scoreboard tracks outstanding producers for the hazard unit. A debug port
// shows committed state only.
module regfile_scb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_vld,
  input  logic [AW-1:0]   iss_rd,
  input  logic            clr0,
  input  logic            clr1,
  input  logic [AW-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data,
  output logic            wr_conflict
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            wrEn0, wrEn1, issEn, retire0, retire1;

  // Qualify writes, issues and retires so that a hardwired r0 never changes
  always_comb begin
    wrEn0   = we0 && !(ZERO_REG && (wa0 == '0));
    wrEn1   = we1 && !(ZERO_REG && (wa1 == '0));
    issEn   = iss_vld && !(ZERO_REG && (iss_rd == '0));
    retire0 = wrEn0 && clr0;
    retire1 = wrEn1 && clr1;
  end

  // Register array update; port 1 is written last so it wins an address tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wrEn0) begin
        regs_q[wa0] <= wd0;
      end
      if (wrEn1) begin
        regs_q[wa1] <= wd1;
      end
    end
  end

  // Scoreboard next state: retires clear first, then a new issue re-claims
  always_comb begin
    busy_d = busy_q;
    if (retire0) begin
      busy_d[wa0] = 1'b0;
    end
    if (retire1) begin
      busy_d[wa1] = 1'b0;
    end
    if (issEn) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // Flag a dual write to one real register so the core can report it
  always_comb begin
    wr_conflict_d = we0 && we1 && (wa0 == wa1) && !(ZERO_REG && (wa0 == '0));
  end

  // Scoreboard and conflict pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Read port 1 with bypass: r0 first, then port 1, then port 0, then storage
  always_comb begin
    rd1 = regs_q[ra1];
    if (wrEn0 && (wa0 == ra1)) begin
      rd1 = wd0;
    end
    if (wrEn1 && (wa1 == ra1)) begin
      rd1 = wd1;
    end
    if (ZERO_REG && (ra1 == '0)) begin
      rd1 = '0;
    end
  end

  // Read port 2 with the same bypass priority as port 1
  always_comb begin
    rd2 = regs_q[ra2];
    if (wrEn0 && (wa0 == ra2)) begin
      rd2 = wd0;
    end
    if (wrEn1 && (wa1 == ra2)) begin
      rd2 = wd1;
    end
    if (ZERO_REG && (ra2 == '0)) begin
      rd2 = '0;
    end
  end

  // Busy hides a register whose producer retires now, since its data is bypassed
  always_comb begin
    busy1 = busy_q[ra1]
            && !((retire0 && (wa0 == ra1)) || (retire1 && (wa1 == ra1)))
            && !(ZERO_REG && (ra1 == '0));
    busy2 = busy_q[ra2]
            && !((retire0 && (wa0 == ra2)) || (retire1 && (wa1 == ra2)))
            && !(ZERO_REG && (ra2 == '0));
  end

  // Debug view of committed state only, no bypass
  always_comb begin
    dbg_data = regs_q[dbg_sel];
    if (ZERO_REG && (dbg_sel == '0)) begin
      dbg_data = '0;
    end
    wr_conflict = wr_conflict_q;
  end

endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb: directed and randomized checks of regfile_scb.
// Two instances share stimulus: A is the default 32x32 with a hardwired r0,
// and B is 16x64 with an ordinary r0. A behavioural model tracks both.
module tb_regfile_scb;

  logic        clk, rst;
  logic        we0, we1, clr0, clr1, iss_vld;
  logic [4:0]  wa0, wa1, ra1, ra2, iss_rd, dbg_sel;
  logic [63:0] wd0, wd1;

  logic [31:0] rd1A, rd2A, dbgA;
  logic        busy1A, busy2A, confA;
  logic [63:0] rd1B, rd2B, dbgB;
  logic        busy1B, busy2B, confB;

  int nChecks = 0;
  int nFail   = 0;

  logic [63:0] memM  [2][32];
  bit          busyM [2][32];
  bit          confM [2];

  regfile_scb dutA (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0[31:0]),
    .we1(we1), .wa1(wa1), .wd1(wd1[31:0]),
    .ra1(ra1), .ra2(ra2), .rd1(rd1A), .rd2(rd2A),
    .busy1(busy1A), .busy2(busy2A),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .clr0(clr0), .clr1(clr1),
    .dbg_sel(dbg_sel), .dbg_data(dbgA), .wr_conflict(confA)
  );

  regfile_scb #(.XLEN(64), .NREG(16), .ZERO_REG(1'b0)) dutB (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0[3:0]), .wd0(wd0),
    .we1(we1), .wa1(wa1[3:0]), .wd1(wd1),
    .ra1(ra1[3:0]), .ra2(ra2[3:0]), .rd1(rd1B), .rd2(rd2B),
    .busy1(busy1B), .busy2(busy2B),
    .iss_vld(iss_vld), .iss_rd(iss_rd[3:0]), .clr0(clr0), .clr1(clr1),
    .dbg_sel(dbg_sel[3:0]), .dbg_data(dbgB), .wr_conflict(confB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  function automatic int mN(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit mZ(int k);
    return (k == 0);
  endfunction

  function automatic logic [63:0] mMask(int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] mRead(int k, logic [4:0] ra);
    int a, w0, w1;
    a  = int'(ra)  % mN(k);
    w0 = int'(wa0) % mN(k);
    w1 = int'(wa1) % mN(k);
    if (mZ(k) && a == 0) return 64'h0;
    if (we1 && w1 == a)  return wd1 & mMask(k);
    if (we0 && w0 == a)  return wd0 & mMask(k);
    return memM[k][a];
  endfunction

  function automatic logic [63:0] mDbg(int k);
    int a;
    a = int'(dbg_sel) % mN(k);
    if (mZ(k) && a == 0) return 64'h0;
    return memM[k][a];
  endfunction

  function automatic bit mBusy(int k, logic [4:0] ra);
    int a, w0, w1;
    bit retiring;
    a  = int'(ra)  % mN(k);
    w0 = int'(wa0) % mN(k);
    w1 = int'(wa1) % mN(k);
    if (mZ(k) && a == 0) return 1'b0;
    retiring = (we0 && clr0 && w0 == a) || (we1 && clr1 && w1 == a);
    return busyM[k][a] && !retiring;
  endfunction

  task automatic mReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        memM[k][i]  = 64'h0;
        busyM[k][i] = 1'b0;
      end
      confM[k] = 1'b0;
    end
  endtask

  task automatic mUpdate(int k);
    int w0, w1, ir;
    if (rst) begin
      mReset();
      return;
    end
    w0 = int'(wa0)    % mN(k);
    w1 = int'(wa1)    % mN(k);
    ir = int'(iss_rd) % mN(k);
    confM[k] = we0 && we1 && (w0 == w1) && !(mZ(k) && w0 == 0);
    if (we0 && !(mZ(k) && w0 == 0)) begin
      memM[k][w0] = wd0 & mMask(k);
      if (clr0) busyM[k][w0] = 1'b0;
    end
    if (we1 && !(mZ(k) && w1 == 0)) begin
      memM[k][w1] = wd1 & mMask(k);
      if (clr1) busyM[k][w1] = 1'b0;
    end
    if (iss_vld && !(mZ(k) && ir == 0)) busyM[k][ir] = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clearInputs();
    we0 = 0; we1 = 0; clr0 = 0; clr1 = 0; iss_vld = 0;
    wa0 = 0; wa1 = 0; ra1 = 0; ra2 = 0; iss_rd = 0; dbg_sel = 0;
    wd0 = 0; wd1 = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    mUpdate(0);
    mUpdate(1);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clearInputs();
    we1 = 1; wa1 = 5; wd1 = 64'hDEADBEEF; iss_vld = 1; iss_rd = 5;
    applyStimulus();
    clearInputs();
    ra1 = 5; dbg_sel = 5;
    #1;
    nChecks++;
    if (dbgA !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL pre_reset_dbg: got %h expected %h", dbgA, 32'hDEADBEEF); end
    nChecks++;
    if (busy1A !== 1'b1) begin nFail++; $display("[TB] FAIL pre_reset_busy: got %b expected 1", busy1A); end
    rst = 1;
    mReset();
    #1;
    nChecks++;
    if (rd1A !== 32'h0) begin nFail++; $display("[TB] FAIL reset_rd1: got %h expected 0", rd1A); end
    nChecks++;
    if (dbgA !== 32'h0) begin nFail++; $display("[TB] FAIL reset_dbg: got %h expected 0", dbgA); end
    nChecks++;
    if (busy1A !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1A); end
    nChecks++;
    if (confA !== 1'b0) begin nFail++; $display("[TB] FAIL reset_conflict: got %b expected 0", confA); end
    nChecks++;
    if (rd1B !== 64'h0) begin nFail++; $display("[TB] FAIL reset_rd1_B: got %h expected 0", rd1B); end
    applyStimulus();
    rst = 0;
    #1;
  endtask

  task automatic test_write_bypass();
    clearInputs();
    we1 = 1; wa1 = 3; wd1 = 64'h12345678; ra1 = 3; dbg_sel = 3;
    #1;
    nChecks++;
    if (rd1A !== 32'h12345678) begin nFail++; $display("[TB] FAIL bypass_rd1: got %h expected %h", rd1A, 32'h12345678); end
    nChecks++;
    if (dbgA !== 32'h0) begin nFail++; $display("[TB] FAIL dbg_no_bypass: got %h expected 0", dbgA); end
    applyStimulus();
    we1 = 0;
    #1;
    nChecks++;
    if (rd1A !== 32'h12345678) begin nFail++; $display("[TB] FAIL stored_rd1: got %h expected %h", rd1A, 32'h12345678); end
    nChecks++;
    if (dbgA !== 32'h12345678) begin nFail++; $display("[TB] FAIL stored_dbg: got %h expected %h", dbgA, 32'h12345678); end
    nChecks++;
    if (rd1B !== 64'h12345678) begin nFail++; $display("[TB] FAIL stored_rd1_B: got %h expected %h", rd1B, 64'h12345678); end
  endtask

  task automatic test_port_priority();
    clearInputs();
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 64'h1; wd1 = 64'h2; ra1 = 7; ra2 = 7; dbg_sel = 7;
    #1;
    nChecks++;
    if (rd1A !== 32'h2) begin nFail++; $display("[TB] FAIL prio_bypass: got %h expected 2", rd1A); end
    applyStimulus();
    we0 = 0; we1 = 0;
    #1;
    nChecks++;
    if (dbgA !== 32'h2) begin nFail++; $display("[TB] FAIL prio_stored: got %h expected 2", dbgA); end
    nChecks++;
    if (confA !== 1'b1) begin nFail++; $display("[TB] FAIL conflict_pulse: got %b expected 1", confA); end
    nChecks++;
    if (confB !== 1'b1) begin nFail++; $display("[TB] FAIL conflict_pulse_B: got %b expected 1", confB); end
    applyStimulus();
    nChecks++;
    if (confA !== 1'b0) begin nFail++; $display("[TB] FAIL conflict_one_cycle: got %b expected 0", confA); end
  endtask

  task automatic test_zero_reg();
    clearInputs();
    we1 = 1; wa1 = 0; wd1 = 64'hFFFFFFFF; iss_vld = 1; iss_rd = 0; ra1 = 0; dbg_sel = 0;
    #1;
    nChecks++;
    if (rd1A !== 32'h0) begin nFail++; $display("[TB] FAIL r0_bypass: got %h expected 0", rd1A); end
    applyStimulus();
    clearInputs();
    we0 = 1; we1 = 1; wa0 = 0; wa1 = 0; wd0 = 64'h5A; wd1 = 64'hA5; ra1 = 0;
    #1;
    nChecks++;
    if (busy1A !== 1'b0) begin nFail++; $display("[TB] FAIL r0_busy: got %b expected 0", busy1A); end
    nChecks++;
    if (busy1B !== 1'b1) begin nFail++; $display("[TB] FAIL r0_busy_B: got %b expected 1", busy1B); end
    applyStimulus();
    we0 = 0; we1 = 0;
    #1;
    nChecks++;
    if (rd1A !== 32'h0) begin nFail++; $display("[TB] FAIL r0_read: got %h expected 0", rd1A); end
    nChecks++;
    if (confA !== 1'b0) begin nFail++; $display("[TB] FAIL r0_conflict: got %b expected 0", confA); end
    nChecks++;
    if (confB !== 1'b1) begin nFail++; $display("[TB] FAIL r0_conflict_B: got %b expected 1", confB); end
    nChecks++;
    if (rd1B !== 64'hA5) begin nFail++; $display("[TB] FAIL r0_read_B: got %h expected a5", rd1B); end
    applyStimulus();
  endtask

  task automatic test_scoreboard();
    clearInputs();
    iss_vld = 1; iss_rd = 9; ra1 = 9;
    #1;
    nChecks++;
    if (busy1A !== 1'b0) begin nFail++; $display("[TB] FAIL issue_not_yet: got %b expected 0", busy1A); end
    applyStimulus();
    iss_vld = 0;
    #1;
    nChecks++;
    if (busy1A !== 1'b1) begin nFail++; $display("[TB] FAIL issue_busy: got %b expected 1", busy1A); end
    we0 = 1; clr0 = 1; wa0 = 9; wd0 = 64'hCAFEF00D;
    #1;
    nChecks++;
    if (busy1A !== 1'b0) begin nFail++; $display("[TB] FAIL retire_busy: got %b expected 0", busy1A); end
    nChecks++;
    if (rd1A !== 32'hCAFEF00D) begin nFail++; $display("[TB] FAIL retire_data: got %h expected %h", rd1A, 32'hCAFEF00D); end
    applyStimulus();
    clearInputs();
    ra1 = 9; iss_vld = 1; iss_rd = 9;
    applyStimulus();
    we1 = 1; clr1 = 1; wa1 = 9; wd1 = 64'h77;
    #1;
    nChecks++;
    if (busy1A !== 1'b0) begin nFail++; $display("[TB] FAIL reissue_retire_now: got %b expected 0", busy1A); end
    applyStimulus();
    clearInputs();
    ra1 = 9;
    #1;
    nChecks++;
    if (busy1A !== 1'b1) begin nFail++; $display("[TB] FAIL reissue_owns: got %b expected 1", busy1A); end
    nChecks++;
    if (busy1B !== 1'b1) begin nFail++; $display("[TB] FAIL reissue_owns_B: got %b expected 1", busy1B); end
  endtask

  task automatic test_random();
    string       names[6] = '{"rd1", "rd2", "busy1", "busy2", "dbg", "conflict"};
    logic [63:0] got[2][6];
    logic [63:0] exp[2][6];
    for (int c = 0; c < 400; c++) begin
      we0     = $urandom_range(0, 1);
      we1     = $urandom_range(0, 1);
      clr0    = $urandom_range(0, 1);
      clr1    = $urandom_range(0, 1);
      iss_vld = $urandom_range(0, 1);
      wa0     = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      wa1     = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      iss_rd  = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      ra1     = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      ra2     = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      dbg_sel = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 31));
      wd0     = {$urandom, $urandom};
      wd1     = {$urandom, $urandom};
      rst     = ($urandom_range(0, 39) == 0);
      if (rst) mReset();
      #1;
      got[0] = '{64'(rd1A), 64'(rd2A), 64'(busy1A), 64'(busy2A), 64'(dbgA), 64'(confA)};
      got[1] = '{rd1B, rd2B, 64'(busy1B), 64'(busy2B), dbgB, 64'(confB)};
      for (int k = 0; k < 2; k++) begin
        exp[k] = '{mRead(k, ra1), mRead(k, ra2), 64'(mBusy(k, ra1)), 64'(mBusy(k, ra2)),
                   mDbg(k), 64'(confM[k])};
        for (int j = 0; j < 6; j++) begin
          nChecks++;
          if (got[k][j] !== exp[k][j]) begin
            nFail++;
            $display("[TB] FAIL random_%s_%s cycle %0d: got %h expected %h",
                     (k == 0) ? "A" : "B", names[j], c, got[k][j], exp[k][j]);
          end
        end
      end
      applyStimulus();
      rst = 0;
    end
    clearInputs();
  endtask

  initial begin
    rst = 1;
    clearInputs();
    mReset();
    applyStimulus();
    rst = 0;
    #1;
    test_reset();
    test_write_bypass();
    test_port_priority();
    test_zero_reg();
    test_scoreboard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
